// File: rtl/pmp_pkg.sv
// Shared PMP types and encodings used by the CSR file and the PMP checker.
package pmp_pkg;

  typedef struct packed {
    logic       l;
    logic [1:0] res;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  typedef enum logic [1:0] {
    A0_OFF   = 2'b00,
    A1_TOR   = 2'b01,
    A2_NA4   = 2'b10,
    A3_NAPOT = 2'b11
  } pmp_mode_e;

  typedef enum logic [1:0] {
    U_MODE = 2'b00,
    S_MODE = 2'b01,
    M_MODE = 2'b11
  } priv_e;

  typedef enum logic [1:0] {
    CSR_READ  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  // Architectural read view of a cfg byte: reserved bits always read as zero.
  function automatic logic [7:0] cfg_read(pmpcfg_t c);
    pmpcfg_t t;
    t     = c;
    t.res = '0;
    return t;
  endfunction

endpackage

// File: rtl/pmp_cfg_byte_warl.sv
// WARL legalisation of one pmpcfg byte: locked bytes keep their value,
// reserved bits clear, and the reserved R=0/W=1 combination drops W.
module pmp_cfg_byte_warl
  import pmp_pkg::*;
(
  input  pmpcfg_t    old_cfg,
  input  logic [7:0] wr_byte,
  input  logic       wr_en,
  output pmpcfg_t    new_cfg
);

  always_comb begin
    new_cfg = old_cfg;
    if (wr_en && !old_cfg.l) begin
      new_cfg     = pmpcfg_t'(wr_byte);
      new_cfg.res = '0;
      if (!new_cfg.r && new_cfg.w) new_cfg.w = 1'b0;
    end
  end

endmodule

// File: rtl/pmp_csr_file.sv
// Machine-mode PMP CSR file: pmpcfg/pmpaddr storage behind a request/response
// handshake, with lock, TOR-lock and WARL enforcement.
module pmp_csr_file
  import pmp_pkg::*;
#(
  parameter int unsigned VLEN      = 31,
  parameter int unsigned PMP_CNT   = 16,
  parameter logic [11:0] CFG_BASE  = 12'h3A0,
  parameter logic [11:0] ADDR_BASE = 12'h3B0
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            io_csr_valid,
  output logic                            io_csr_ready,
  input  logic [11:0]                     io_csr_addr,
  input  logic [1:0]                      io_csr_op,
  input  logic [31:0]                     io_csr_wdata,
  input  logic [1:0]                      io_csr_prv,
  output logic                            io_rsp_valid,
  input  logic                            io_rsp_ready,
  output logic [31:0]                     io_rsp_rdata,
  output logic                            io_rsp_illegal,
  output pmpcfg_t [PMP_CNT-1:0]           io_pmpcfg,
  output logic    [PMP_CNT-1:0][VLEN:0]   io_pmpaddr,
  output logic                            io_cfg_update
);

  localparam int unsigned CFG_REGS = PMP_CNT / 4;
  localparam int unsigned ADDR_W   = VLEN + 1;

  typedef enum logic [1:0] {IDLE, MODIFY, RESP} state_e;

  state_e                        state;
  logic [11:0]                   addr_q;
  csr_op_e                       op_q;
  logic [31:0]                   wdata_q;
  logic [1:0]                    prv_q;

  pmpcfg_t [PMP_CNT-1:0]         cfg_q, cfg_nxt;
  logic [PMP_CNT-1:0][VLEN:0]    addr_reg_q, addr_nxt;
  logic [PMP_CNT-1:0]            addr_lock;

  logic [11:0]                   cfg_off, addr_off;
  logic                          is_cfg, is_addr, legal, do_write, cfg_wr, changed;
  logic [31:0]                   old_val, new_val;
  pmpcfg_t [3:0]                 sel_cfg, warl_cfg;

  assign cfg_off  = addr_q - CFG_BASE;
  assign addr_off = addr_q - ADDR_BASE;
  assign is_cfg   = (addr_q >= CFG_BASE)  && (32'(cfg_off)  < CFG_REGS);
  assign is_addr  = (addr_q >= ADDR_BASE) && (32'(addr_off) < PMP_CNT);
  assign legal    = (prv_q == M_MODE) && (is_cfg || is_addr);

  // set/clear with a zero operand is architecturally a pure read
  assign do_write = legal && ((op_q == CSR_WRITE) ||
                              (((op_q == CSR_SET) || (op_q == CSR_CLEAR)) && (wdata_q != '0)));
  assign cfg_wr   = do_write && is_cfg;

  // Lock state is taken from the pre-write registers only.
  for (genvar i = 0; i < PMP_CNT; i++) begin : g_lock
    if (i < PMP_CNT - 1) begin : g_tor
      assign addr_lock[i] = cfg_q[i].l || (cfg_q[i+1].l && (cfg_q[i+1].a == A1_TOR));
    end else begin : g_last
      assign addr_lock[i] = cfg_q[i].l;
    end
  end

  always_comb begin
    sel_cfg = '0;
    old_val = '0;
    for (int unsigned j = 0; j < CFG_REGS; j++) begin
      if (is_cfg && (32'(cfg_off) == j)) sel_cfg = cfg_q[j*4 +: 4];
    end
    if (is_cfg) begin
      for (int unsigned k = 0; k < 4; k++) old_val[k*8 +: 8] = cfg_read(sel_cfg[k]);
    end
    for (int unsigned i = 0; i < PMP_CNT; i++) begin
      if (is_addr && (32'(addr_off) == i)) old_val = 32'(addr_reg_q[i]);
    end
    if (!legal) old_val = '0;
  end

  always_comb begin
    unique case (op_q)
      CSR_WRITE: new_val = wdata_q;
      CSR_SET:   new_val = old_val | wdata_q;
      CSR_CLEAR: new_val = old_val & ~wdata_q;
      default:   new_val = old_val;
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_warl
    pmp_cfg_byte_warl u_warl (
      .old_cfg (sel_cfg[k]),
      .wr_byte (new_val[k*8 +: 8]),
      .wr_en   (cfg_wr),
      .new_cfg (warl_cfg[k])
    );
  end

  always_comb begin
    cfg_nxt  = cfg_q;
    addr_nxt = addr_reg_q;
    for (int unsigned j = 0; j < CFG_REGS; j++) begin
      if (is_cfg && (32'(cfg_off) == j)) cfg_nxt[j*4 +: 4] = warl_cfg;
    end
    for (int unsigned i = 0; i < PMP_CNT; i++) begin
      if (do_write && is_addr && (32'(addr_off) == i) && !addr_lock[i])
        addr_nxt[i] = ADDR_W'(new_val);
    end
  end

  assign changed = (cfg_nxt != cfg_q) || (addr_nxt != addr_reg_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      io_csr_ready   <= 1'b0;
      io_rsp_valid   <= 1'b0;
      io_rsp_rdata   <= '0;
      io_rsp_illegal <= 1'b0;
      io_cfg_update  <= 1'b0;
      addr_q         <= '0;
      op_q           <= CSR_READ;
      wdata_q        <= '0;
      prv_q          <= '0;
      cfg_q          <= '0;
      addr_reg_q     <= '0;
    end else begin
      io_cfg_update <= 1'b0;
      unique case (state)
        IDLE: begin
          if (io_csr_valid && io_csr_ready) begin
            addr_q       <= io_csr_addr;
            op_q         <= csr_op_e'(io_csr_op);
            wdata_q      <= io_csr_wdata;
            prv_q        <= io_csr_prv;
            io_csr_ready <= 1'b0;
            state        <= MODIFY;
          end else begin
            io_csr_ready <= 1'b1;
          end
        end
        MODIFY: begin
          io_rsp_rdata   <= old_val;
          io_rsp_illegal <= !legal;
          cfg_q          <= cfg_nxt;
          addr_reg_q     <= addr_nxt;
          io_cfg_update  <= changed;
          io_rsp_valid   <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (io_rsp_ready) begin
            io_rsp_valid <= 1'b0;
            io_csr_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_pmpcfg  = cfg_q;
  assign io_pmpaddr = addr_reg_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Scoreboard bench for pmp_csr_file: expected responses queued at request
// time and checked when the DUT hands the response over.
module tb_pmp_csr_file;
  import pmp_pkg::*;

  localparam int unsigned VLEN    = 31;
  localparam int unsigned PMP_CNT = 16;

  logic                         clock = 1'b0;
  logic                         reset_n;
  logic                         io_csr_valid;
  logic                         io_csr_ready;
  logic [11:0]                  io_csr_addr;
  logic [1:0]                   io_csr_op;
  logic [31:0]                  io_csr_wdata;
  logic [1:0]                   io_csr_prv;
  logic                         io_rsp_valid;
  logic                         io_rsp_ready;
  logic [31:0]                  io_rsp_rdata;
  logic                         io_rsp_illegal;
  pmpcfg_t [PMP_CNT-1:0]        io_pmpcfg;
  logic [PMP_CNT-1:0][VLEN:0]   io_pmpaddr;
  logic                         io_cfg_update;

  pmp_csr_file #(
    .VLEN      (VLEN),
    .PMP_CNT   (PMP_CNT),
    .CFG_BASE  (12'h3A0),
    .ADDR_BASE (12'h3B0)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .io_csr_valid   (io_csr_valid),
    .io_csr_ready   (io_csr_ready),
    .io_csr_addr    (io_csr_addr),
    .io_csr_op      (io_csr_op),
    .io_csr_wdata   (io_csr_wdata),
    .io_csr_prv     (io_csr_prv),
    .io_rsp_valid   (io_rsp_valid),
    .io_rsp_ready   (io_rsp_ready),
    .io_rsp_rdata   (io_rsp_rdata),
    .io_rsp_illegal (io_rsp_illegal),
    .io_pmpcfg      (io_pmpcfg),
    .io_pmpaddr     (io_pmpaddr),
    .io_cfg_update  (io_cfg_update)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [32:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   upd_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (io_cfg_update) upd_cnt++;
    if (io_rsp_valid && io_rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check(e.tag, 64'({io_rsp_illegal, io_rsp_rdata}), 64'(e.v));
      end
    end
  end

  task automatic csr_req(input string tag, input logic [11:0] a, input logic [1:0] op,
                         input logic [31:0] wd, input logic [1:0] prv,
                         input logic [31:0] exp_rdata, input logic exp_ill, input int exp_upd);
    int   n;
    int   u0;
    exp_t e;
    e.tag = tag;
    e.v   = {exp_ill, exp_rdata};
    exp_q.push_back(e);
    u0 = upd_cnt;
    @(negedge clock);
    io_csr_valid = 1'b1;
    io_csr_addr  = a;
    io_csr_op    = op;
    io_csr_wdata = wd;
    io_csr_prv   = prv;
    n = 0;
    while (!io_csr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check({tag, "_req_timeout"}, 64'd0, 64'd1);
    @(negedge clock);
    io_csr_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_rsp_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    check({tag, "_upd"}, 64'(upd_cnt - u0), 64'(exp_upd));
  endtask

  localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_SET = 2'b10, OP_CLR = 2'b11;
  localparam logic [1:0] PM = 2'b11, PS = 2'b01, PU = 2'b00;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n      = 1'b0;
    io_csr_valid = 1'b0;
    io_csr_addr  = '0;
    io_csr_op    = '0;
    io_csr_wdata = '0;
    io_csr_prv   = '0;
    io_rsp_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ready",   64'(io_csr_ready),   64'd0);
    check("rst_rspv",    64'(io_rsp_valid),   64'd0);
    check("rst_rdata",   64'(io_rsp_rdata),   64'd0);
    check("rst_illegal", 64'(io_rsp_illegal), 64'd0);
    check("rst_update",  64'(io_cfg_update),  64'd0);
    check("rst_cfg",     64'(io_pmpcfg == '0),  64'd1);
    check("rst_addr",    64'(io_pmpaddr == '0), 64'd1);
    reset_n = 1'b1;

    csr_req("rd_cfg0_rst",  12'h3A0, OP_RD, 32'h0, PM, 32'h0, 1'b0, 0);
    csr_req("rd_addr5_rst", 12'h3B5, OP_RD, 32'h0, PM, 32'h0, 1'b0, 0);

    csr_req("wr_cfg0",      12'h3A0, OP_WR, 32'h8F1B0F07, PM, 32'h0, 1'b0, 1);
    check("cfg3_l",     64'(io_pmpcfg[3].l), 64'd1);
    check("cfg2_a",     64'(io_pmpcfg[2].a), 64'd3);
    csr_req("rd_cfg0_a",    12'h3A0, OP_RD, 32'h0, PM, 32'h8F1B0F07, 1'b0, 0);
    csr_req("wr_cfg0_zero", 12'h3A0, OP_WR, 32'h0, PM, 32'h8F1B0F07, 1'b0, 1);
    csr_req("rd_cfg0_b",    12'h3A0, OP_RD, 32'h0, PM, 32'h8F000000, 1'b0, 0);

    csr_req("wr_cfg0_rw",   12'h3A0, OP_WR, 32'h00000002, PM, 32'h8F000000, 1'b0, 0);
    csr_req("rd_cfg0_c",    12'h3A0, OP_RD, 32'h0, PM, 32'h8F000000, 1'b0, 0);
    csr_req("wr_cfg0_res",  12'h3A0, OP_WR, 32'h00000067, PM, 32'h8F000000, 1'b0, 1);
    csr_req("rd_cfg0_d",    12'h3A0, OP_RD, 32'h0, PM, 32'h8F000007, 1'b0, 0);
    check("cfg0_res",   64'(io_pmpcfg[0]), 64'h07);

    csr_req("set_cfg5",     12'h3A1, OP_SET, 32'h00008800, PM, 32'h0, 1'b0, 1);
    check("cfg5",       64'(io_pmpcfg[5]), 64'h88);
    csr_req("wr_addr4_tor", 12'h3B4, OP_WR, 32'h1234, PM, 32'h0, 1'b0, 0);
    check("addr4",      64'(io_pmpaddr[4]), 64'h0);
    csr_req("wr_addr5_l",   12'h3B5, OP_WR, 32'hFF, PM, 32'h0, 1'b0, 0);
    csr_req("wr_addr6",     12'h3B6, OP_WR, 32'h1234, PM, 32'h0, 1'b0, 1);
    check("addr6",      64'(io_pmpaddr[6]), 64'h1234);
    csr_req("wr_addr2_tor", 12'h3B2, OP_WR, 32'h55, PM, 32'h0, 1'b0, 0);
    csr_req("set_addr6_0",  12'h3B6, OP_SET, 32'h0, PM, 32'h1234, 1'b0, 0);
    csr_req("clr_addr6",    12'h3B6, OP_CLR, 32'h0030, PM, 32'h1234, 1'b0, 1);
    csr_req("rd_addr6",     12'h3B6, OP_RD, 32'h0, PM, 32'h1204, 1'b0, 0);

    csr_req("wr_addr0_s",   12'h3B0, OP_WR, 32'hFFFF, PS, 32'h0, 1'b1, 0);
    check("addr0",      64'(io_pmpaddr[0]), 64'h0);
    csr_req("rd_cfg0_u",    12'h3A0, OP_RD, 32'h0, PU, 32'h0, 1'b1, 0);
    csr_req("rd_3c0",       12'h3C0, OP_RD, 32'h0, PM, 32'h0, 1'b1, 0);
    csr_req("rd_3a4",       12'h3A4, OP_RD, 32'h0, PM, 32'h0, 1'b1, 0);
    csr_req("wr_3a4",       12'h3A4, OP_WR, 32'h1, PM, 32'h0, 1'b1, 0);
    csr_req("rd_3a3",       12'h3A3, OP_RD, 32'h0, PM, 32'h0, 1'b0, 0);
    csr_req("wr_addr15",    12'h3BF, OP_WR, 32'hCAFE, PM, 32'h0, 1'b0, 1);
    csr_req("rd_addr15",    12'h3BF, OP_RD, 32'h0, PM, 32'hCAFE, 1'b0, 0);

    // Stall the response, then reset while it is pending (response dropped).
    io_rsp_ready = 1'b0;
    @(negedge clock);
    io_csr_valid = 1'b1;
    io_csr_addr  = 12'h3B7;
    io_csr_op    = OP_WR;
    io_csr_wdata = 32'hABCD;
    io_csr_prv   = PM;
    n = 0;
    while (!io_csr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check("stall_req_timeout", 64'd0, 64'd1);
    @(negedge clock);
    io_csr_valid = 1'b0;
    n = 0;
    while (!io_rsp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("stall_rspv",  64'(io_rsp_valid), 64'd1);
    check("stall_addr7", 64'(io_pmpaddr[7]), 64'hABCD);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("hold_rspv",  64'(io_rsp_valid), 64'd1);
      check("hold_rdata", 64'(io_rsp_rdata), 64'd0);
      check("hold_ill",   64'(io_rsp_illegal), 64'd0);
      check("hold_ready", 64'(io_csr_ready), 64'd0);
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_rspv",  64'(io_rsp_valid), 64'd0);
    check("mid_rst_addr7", 64'(io_pmpaddr[7]), 64'h0);
    check("mid_rst_addr6", 64'(io_pmpaddr[6]), 64'h0);
    check("mid_rst_cfg",   64'(io_pmpcfg == '0), 64'd1);
    check("mid_rst_ready", 64'(io_csr_ready), 64'd0);
    repeat (2) @(negedge clock);
    reset_n      = 1'b1;
    io_rsp_ready = 1'b1;
    csr_req("rd_cfg0_post", 12'h3A0, OP_RD, 32'h0, PM, 32'h0, 1'b0, 0);
    csr_req("wr_cfg0_post", 12'h3A0, OP_WR, 32'h00000002, PM, 32'h0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
